// File: rtl/unidade_muldiv_pkg.sv
// Shared constants, funct3 encodings and FSM states for the RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int LARGURA   = 32;
  localparam int LARG_END  = 5;
  localparam int ITERACOES = 32;
  localparam int LARG_CONT = $clog2(ITERACOES);

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CALC    = 2'd1,
    CORRIGE = 2'd2,
    FIM     = 2'd3
  } estado_e;

  // Two's-complement negate when neg is set; used for operand magnitudes and result correction.
  function automatic logic [LARGURA-1:0] nega_se(input logic neg, input logic [LARGURA-1:0] v);
    return neg ? ({LARGURA{1'b0}} - v) : v;
  endfunction

endpackage

// File: rtl/unidade_muldiv_if.sv
// Request/result bundle between the register bank side and the muldiv unit.
interface unidade_muldiv_if;
  import muldiv_pkg::*;

  logic                inicio;
  logic [2:0]          funct3;
  logic [LARG_END-1:0] endereco_regd_in;
  logic [LARGURA-1:0]  valor_reg1;
  logic [LARGURA-1:0]  valor_reg2;
  logic                ocupado;
  logic                pronto;
  logic                reg_escrita;
  logic [LARG_END-1:0] endereco_regd;
  logic [LARGURA-1:0]  dado_escrita;

  // Requester side: issues operations and observes the write-back.
  modport master (
    output inicio, funct3, endereco_regd_in, valor_reg1, valor_reg2,
    input  ocupado, pronto, reg_escrita, endereco_regd, dado_escrita
  );

  // Unit side.
  modport slave (
    input  inicio, funct3, endereco_regd_in, valor_reg1, valor_reg2,
    output ocupado, pronto, reg_escrita, endereco_regd, dado_escrita
  );
endinterface

// File: rtl/unidade_muldiv_passo.sv
// One iteration of the iterative datapath: shift-add multiply or restoring divide step.
// Multiply: {acc_hi, acc_lo} is the running product, acc_lo starts as the multiplier.
// Divide:   acc_hi is the partial remainder, acc_lo shifts the dividend out and the quotient in.
module muldiv_passo
  import muldiv_pkg::*;
(
  input  logic               modo_div,
  input  logic [LARGURA-1:0] acc_hi,
  input  logic [LARGURA-1:0] acc_lo,
  input  logic [LARGURA-1:0] operando,
  output logic [LARGURA-1:0] hi_prox,
  output logic [LARGURA-1:0] lo_prox
);

  logic [LARGURA:0] soma_s;
  logic [LARGURA:0] parcial_s;
  logic [LARGURA:0] tentativa_s;

  // Compute both step flavours and select by mode; bit LARGURA of tentativa_s is the borrow.
  always_comb begin
    soma_s      = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operando} : {(LARGURA+1){1'b0}});
    parcial_s   = {acc_hi, acc_lo[LARGURA-1]};
    tentativa_s = parcial_s - {1'b0, operando};
    if (modo_div) begin
      if (!tentativa_s[LARGURA]) begin
        hi_prox = tentativa_s[LARGURA-1:0];
        lo_prox = {acc_lo[LARGURA-2:0], 1'b1};
      end else begin
        hi_prox = parcial_s[LARGURA-1:0];
        lo_prox = {acc_lo[LARGURA-2:0], 1'b0};
      end
    end else begin
      hi_prox = soma_s[LARGURA:1];
      lo_prox = {soma_s[0], acc_lo[LARGURA-1:1]};
    end
  end

endmodule

// File: rtl/unidade_muldiv.sv
// Iterative RV32M multiply/divide unit writing its result back into the register bank.
module unidade_muldiv
  import muldiv_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  unidade_muldiv_if.slave  bus
);

  estado_e                estado_q, estado_d;
  logic [LARG_CONT-1:0]   cont_q, cont_d;
  logic [LARGURA-1:0]     acc_hi_q, acc_hi_d;
  logic [LARGURA-1:0]     acc_lo_q, acc_lo_d;
  logic [LARGURA-1:0]     operando_q, operando_d;
  logic [2:0]             funct3_q, funct3_d;
  logic                   neg_res_q, neg_res_d;
  logic                   neg_rem_q, neg_rem_d;
  logic [LARG_END-1:0]    rd_q, rd_d;
  logic [LARGURA-1:0]     dado_q, dado_d;
  logic                   pronto_q, pronto_d;
  logic                   ocupado_q, ocupado_d;

  logic                   e_div_s;
  logic                   sinal_a_s, sinal_b_s;
  logic [LARGURA-1:0]     mag_a_s, mag_b_s;
  logic                   curto_s;
  logic [LARGURA-1:0]     valor_curto_s;
  logic [LARGURA-1:0]     passo_hi_s, passo_lo_s;
  logic [2*LARGURA-1:0]   produto_s;
  logic [LARGURA-1:0]     quoc_s, resto_s;
  logic [LARGURA-1:0]     resultado_s;

  muldiv_passo u_passo (
    .modo_div (funct3_q[2]),
    .acc_hi   (acc_hi_q),
    .acc_lo   (acc_lo_q),
    .operando (operando_q),
    .hi_prox  (passo_hi_s),
    .lo_prox  (passo_lo_s)
  );

  // Decode operand signedness, magnitudes and the accept-time short-circuit cases.
  always_comb begin
    e_div_s = bus.funct3[2];
    if (e_div_s) begin
      sinal_a_s = bus.valor_reg1[LARGURA-1] & ~bus.funct3[0];
      sinal_b_s = bus.valor_reg2[LARGURA-1] & ~bus.funct3[0];
    end else begin
      sinal_a_s = bus.valor_reg1[LARGURA-1] & (bus.funct3 != F3_MULHU);
      sinal_b_s = bus.valor_reg2[LARGURA-1] & ((bus.funct3 == F3_MUL) | (bus.funct3 == F3_MULH));
    end
    mag_a_s = nega_se(sinal_a_s, bus.valor_reg1);
    mag_b_s = nega_se(sinal_b_s, bus.valor_reg2);
    curto_s       = 1'b0;
    valor_curto_s = {LARGURA{1'b0}};
    if (e_div_s && (bus.valor_reg2 == {LARGURA{1'b0}})) begin
      curto_s       = 1'b1;
      valor_curto_s = bus.funct3[1] ? bus.valor_reg1 : {LARGURA{1'b1}};
    end else if (e_div_s && !bus.funct3[0] && (bus.valor_reg1 == {1'b1, {(LARGURA-1){1'b0}}})
                 && (bus.valor_reg2 == {LARGURA{1'b1}})) begin
      curto_s       = 1'b1;
      valor_curto_s = bus.funct3[1] ? {LARGURA{1'b0}} : {1'b1, {(LARGURA-1){1'b0}}};
    end else begin
      curto_s       = 1'b0;
      valor_curto_s = {LARGURA{1'b0}};
    end
  end

  // Apply sign correction to the finished accumulators and pick the architectural result word.
  always_comb begin
    produto_s = {acc_hi_q, acc_lo_q};
    if (neg_res_q) begin
      produto_s = {(2*LARGURA){1'b0}} - {acc_hi_q, acc_lo_q};
    end else begin
      produto_s = {acc_hi_q, acc_lo_q};
    end
    quoc_s  = nega_se(neg_res_q, acc_lo_q);
    resto_s = nega_se(neg_rem_q, acc_hi_q);
    case (funct3_q)
      F3_MUL:                     resultado_s = produto_s[LARGURA-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: resultado_s = produto_s[2*LARGURA-1:LARGURA];
      F3_DIV, F3_DIVU:            resultado_s = quoc_s;
      F3_REM, F3_REMU:            resultado_s = resto_s;
      default:                    resultado_s = {LARGURA{1'b0}};
    endcase
  end

  // Next-state logic: accept, iterate, correct, announce.
  always_comb begin
    estado_d   = estado_q;
    cont_d     = cont_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    operando_d = operando_q;
    funct3_d   = funct3_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    rd_d       = rd_q;
    dado_d     = dado_q;
    case (estado_q)
      OCIOSO: begin
        if (bus.inicio) begin
          funct3_d  = bus.funct3;
          rd_d      = bus.endereco_regd_in;
          neg_res_d = sinal_a_s ^ sinal_b_s;
          neg_rem_d = sinal_a_s;
          acc_hi_d  = {LARGURA{1'b0}};
          if (e_div_s) begin
            acc_lo_d   = mag_a_s;
            operando_d = mag_b_s;
          end else begin
            acc_lo_d   = mag_b_s;
            operando_d = mag_a_s;
          end
          if (curto_s) begin
            dado_d   = valor_curto_s;
            estado_d = FIM;
          end else begin
            cont_d   = LARG_CONT'(ITERACOES - 1);
            estado_d = CALC;
          end
        end else begin
          estado_d = OCIOSO;
        end
      end
      CALC: begin
        acc_hi_d = passo_hi_s;
        acc_lo_d = passo_lo_s;
        cont_d   = cont_q - {{(LARG_CONT-1){1'b0}}, 1'b1};
        if (cont_q == {LARG_CONT{1'b0}}) begin
          estado_d = CORRIGE;
        end else begin
          estado_d = CALC;
        end
      end
      CORRIGE: begin
        dado_d   = resultado_s;
        estado_d = FIM;
      end
      FIM: begin
        estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
    pronto_d  = (estado_d == FIM);
    ocupado_d = (estado_d != OCIOSO);
  end

  // State, datapath and output registers; reset aborts any operation in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q   <= OCIOSO;
      cont_q     <= {LARG_CONT{1'b0}};
      acc_hi_q   <= {LARGURA{1'b0}};
      acc_lo_q   <= {LARGURA{1'b0}};
      operando_q <= {LARGURA{1'b0}};
      funct3_q   <= 3'b000;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      rd_q       <= {LARG_END{1'b0}};
      dado_q     <= {LARGURA{1'b0}};
      pronto_q   <= 1'b0;
      ocupado_q  <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      cont_q     <= cont_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      operando_q <= operando_d;
      funct3_q   <= funct3_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      rd_q       <= rd_d;
      dado_q     <= dado_d;
      pronto_q   <= pronto_d;
      ocupado_q  <= ocupado_d;
    end
  end

  assign bus.ocupado       = ocupado_q;
  assign bus.pronto        = pronto_q;
  assign bus.reg_escrita   = pronto_q;
  assign bus.endereco_regd = rd_q;
  assign bus.dado_escrita  = dado_q;

endmodule
